// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the processor-memory port between ICache and DCache
// controllers, routes accept responses and owner-tracked returning tags.
//
// Ports:
//   clock, reset            clock; asynchronous active-low reset
//   Ictrl2mem_command/addr  ICache request (BUS_NONE or BUS_LOAD)
//   Dctrl2mem_command/addr  DCache request (BUS_NONE, BUS_LOAD, BUS_STORE)
//   Dctrl2mem_data          DCache store data
//   rob_low                 ROB nearly empty: ICache preferred on conflict
//   mem2proc_response       memory accept tag (0 = refused)
//   mem2proc_tag            tag of returning data (0 = none)
//   proc2mem_command/addr/data  granted request on the memory bus
//   reject_I_req/D_req      requester active but not granted
//   Imem2Ictrl_*/Dmem2Dctrl_*   per-side response and routed tag
//   outstanding_count       number of valid tag-table entries
//   tag_error               sticky: nonzero tag returned with no owner

`ifndef XLEN
`define XLEN 32
`endif

package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  BUS_COMMAND        Ictrl2mem_command,
    input  logic [`XLEN-1:0]  Ictrl2mem_addr,
    input  BUS_COMMAND        Dctrl2mem_command,
    input  logic [`XLEN-1:0]  Dctrl2mem_addr,
    input  logic [63:0]       Dctrl2mem_data,
    input  logic              rob_low,
    input  logic [3:0]        mem2proc_response,
    input  logic [3:0]        mem2proc_tag,
    output BUS_COMMAND        proc2mem_command,
    output logic [`XLEN-1:0]  proc2mem_addr,
    output logic [63:0]       proc2mem_data,
    output logic              reject_I_req,
    output logic              reject_D_req,
    output logic [3:0]        Imem2Ictrl_response,
    output logic [3:0]        Imem2Ictrl_tag,
    output logic [3:0]        Dmem2Dctrl_response,
    output logic [3:0]        Dmem2Dctrl_tag,
    output logic [3:0]        outstanding_count,
    output logic              tag_error
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    // Entry 0 is never used: tag 0 means "none" on both buses.
    logic [15:0]   valid_q, valid_d;
    // Owner bit per entry: 1 = DCache, 0 = ICache.
    logic [15:0]   owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [3:0]    count_q, count_d;
    logic          err_q, err_d;

    logic act_i, act_d, both;
    logic starved;
    logic gnt_i, gnt_d;
    logic alloc;
    logic ret_hit, orphan;

    // Arbitration and starvation counter
    always_comb begin
        // Gating with reset holds every combinational output at zero
        // while reset is asserted.
        act_i   = reset && (Ictrl2mem_command != BUS_NONE);
        act_d   = reset && (Dctrl2mem_command != BUS_NONE);
        both    = act_i && act_d;
        starved = (starve_q == LIMIT);
        gnt_i   = 1'b0;
        gnt_d   = 1'b0;
        starve_d = '0;
        if (both) begin
            // Preferred side wins unless the other one has starved.
            if (rob_low ^ starved) begin
                gnt_i = 1'b1;
            end else begin
                gnt_d = 1'b1;
            end
            if (!starved) begin
                starve_d = starve_q + 1'b1;
            end
        end else begin
            gnt_i = act_i;
            gnt_d = act_d;
        end
    end

    // Bus drive and response routing
    always_comb begin
        proc2mem_command    = BUS_NONE;
        proc2mem_addr       = '0;
        proc2mem_data       = '0;
        Imem2Ictrl_response = '0;
        Dmem2Dctrl_response = '0;
        if (gnt_i) begin
            proc2mem_command    = Ictrl2mem_command;
            proc2mem_addr       = Ictrl2mem_addr;
            Imem2Ictrl_response = mem2proc_response;
        end else if (gnt_d) begin
            proc2mem_command    = Dctrl2mem_command;
            proc2mem_addr       = Dctrl2mem_addr;
            proc2mem_data       = Dctrl2mem_data;
            Dmem2Dctrl_response = mem2proc_response;
        end
        reject_I_req = act_i && !gnt_i;
        reject_D_req = act_d && !gnt_d;
    end

    // Tag table: retire then allocate, so a same-cycle allocate of the
    // returning tag leaves the entry valid under its new owner.
    always_comb begin
        alloc   = (proc2mem_command == BUS_LOAD) &&
                  (mem2proc_response != 4'd0);
        ret_hit = reset && (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
        orphan  = reset && (mem2proc_tag != 4'd0) && !valid_q[mem2proc_tag];

        Imem2Ictrl_tag = '0;
        Dmem2Dctrl_tag = '0;
        if (ret_hit) begin
            if (owner_q[mem2proc_tag]) begin
                Dmem2Dctrl_tag = mem2proc_tag;
            end else begin
                Imem2Ictrl_tag = mem2proc_tag;
            end
        end

        valid_d = valid_q;
        owner_d = owner_q;
        if (ret_hit) begin
            valid_d[mem2proc_tag] = 1'b0;
        end
        if (alloc) begin
            valid_d[mem2proc_response] = 1'b1;
            owner_d[mem2proc_response] = gnt_d;
        end

        err_d = err_q || orphan;

        count_d = '0;
        for (int i = 1; i < 16; i++) begin
            count_d = count_d + {3'b000, valid_d[i]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            owner_q  <= '0;
            starve_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign outstanding_count = count_q;
    assign tag_error         = err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single processor–memory port between the ICache controller and the DCache controller. Each cycle it picks one requester, drives the memory bus, and returns the memory's accept/reject response to the winner. The loser gets `reject_I_req`/`reject_D_req`. A tag-ownership table records which controller owns each outstanding load tag, so returning data tags are delivered only to their owner. It sits between both cache controllers and the memory model, directly below the fetch and LSQ cache paths.

## Interface
- `STARVE_LIMIT`, 8: consecutive rejected conflict cycles before the losing requester is forced to win.
- `clock`  in  1  system clock, all state on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `Ictrl2mem_command`  in  BUS_COMMAND  ICache request; only BUS_NONE or BUS_LOAD are legal.
- `Ictrl2mem_addr`  in  `XLEN`  ICache block address.
- `Dctrl2mem_command`  in  BUS_COMMAND  DCache request: BUS_NONE, BUS_LOAD or BUS_STORE.
- `Dctrl2mem_addr`  in  `XLEN`  DCache block address.
- `Dctrl2mem_data`  in  64  DCache store data.
- `rob_low`  in  1  ROB empty or near-empty; ICache gets priority.
- `mem2proc_response`  in  4  memory accept tag; 0 means refused.
- `mem2proc_tag`  in  4  tag of data returning this cycle; 0 means none.
- `proc2mem_command`  out  BUS_COMMAND  granted command.
- `proc2mem_addr`  out  `XLEN`  granted address.
- `proc2mem_data`  out  64  `Dctrl2mem_data` when D is granted, else 0.
- `reject_I_req`, `reject_D_req`  out  1  requester is active and was not granted.
- `Imem2Ictrl_response`, `Imem2Ictrl_tag`  out  4  I-side response and routed tag.
- `Dmem2Dctrl_response`, `Dmem2Dctrl_tag`  out  4  D-side response and routed tag.
- `outstanding_count`  out  4  number of valid table entries.
- `tag_error`  out  1  sticky flag: a nonzero tag returned with no valid owner.

## Operation
- **Active requester:** a requester is active when its command is not BUS_NONE.
- **Arbitration (combinational):**
  - If only one requester is active, it wins.
  - If both are active, the preferred side wins. I is preferred when `rob_low`=1; D is preferred otherwise.
  - If `starve_cnt` equals `STARVE_LIMIT`, the non-preferred side wins instead.
- **Bus drive:**
  - The winner's command and address are driven onto the bus.
  - With no active requester, the bus drives BUS_NONE, address 0 and data 0.
- **Response:**
  - The winner's response output equals `mem2proc_response`; the loser's response output is 0.
  - A winner seeing response 0 is not rejected; its controller retries.
- **Starvation counter (`starve_cnt`, 0..`STARVE_LIMIT`):**
  - Increments on each cycle where both sides are active and the preferred side wins.
  - Clears to 0 when the non-preferred side wins, or when either side is inactive.
  - Saturates at `STARVE_LIMIT`.
- **Tag table (15 entries, indexed 1..15, each holding valid plus owner):**
  - Allocate: when a granted BUS_LOAD has `mem2proc_response`≠0, set `valid[response]`=1 and record the owner (I or D).
  - Stores never allocate an entry.
  - Retire: when `mem2proc_tag`≠0 and that entry is valid, route the tag to the owner's `*_tag` output, drive the other side's tag output to 0, and clear valid.
  - Allocate and retire of the same tag in the same cycle: allocate wins (entry stays valid with the new owner). The returning tag is still routed to the old owner.
  - Orphan tag (entry not valid): both tag outputs are 0 and `tag_error` sets.
- **Count:** `outstanding_count` equals popcount(valid), registered.

## Timing
- **Same cycle:** grant, rejects, bus drive and response routing are combinational.
- **Zero latency:** tag routing is combinational from the registered table, so a tag is routed on the cycle it arrives.
- **Next edge:** allocation is visible in the table one cycle after the grant. A tag can therefore return at the earliest on the cycle after acceptance.
- **While `reset`=0:**
  - Table entries are invalid, `starve_cnt`=0, `tag_error`=0, `outstanding_count`=0.
  - `proc2mem_command`=BUS_NONE, address and data are 0.
  - All response and tag outputs are 0; both rejects are 0.
- **Reset mid-operation:** outstanding entries are discarded. Tags returning after reset release count as orphans.

## Test plan
- **Solo I request:** I LOAD at 0x100, D idle, `mem2proc_response`=3 → bus LOAD 0x100, `Imem2Ictrl_response`=3, `reject_I_req`=0. When `mem2proc_tag`=3 arrives later → `Imem2Ictrl_tag`=3, `Dmem2Dctrl_tag`=0, `outstanding_count` returns to 0.
- **Conflict, `rob_low`=0:** I and D both active → D granted, `reject_I_req`=1. With `rob_low`=1 → I granted, `reject_D_req`=1.
- **Starvation:** both active continuously, `rob_low`=0, `STARVE_LIMIT`=8 → D granted for 8 cycles, I granted on the 9th, then D again.
- **Store:** D STORE, data 0xDEADBEEF, response 5 → `proc2mem_data`=0xDEADBEEF, no table entry, `outstanding_count` unchanged.
- **Tag reuse:** tag 7 held by D returns while I's grant receives response 7 in the same cycle → `Dmem2Dctrl_tag`=7; the entry stays valid with owner I; a later tag 7 routes to I.
- **Orphan and reset:** tag 9 returns with no valid entry → both tag outputs 0, `tag_error`=1. Assert `reset`=0 mid-burst → all outputs at reset values immediately, `tag_error`=0.
